// File: rtl/bcd_event_counter.sv
// ============================================================================
// Module   : bcd_event_counter
// Brief    : Rising-edge event counter with 4-digit packed-BCD count and a
//            sticky overflow flag. Optional multiplexed seven-segment display
//            driver enabled by defining SEG_MUX_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_event_counter #(
  parameter int SCAN_DIV = 1024
) (
  input  logic        tick,
  input  logic        reset,
  input  logic        enable,
  input  logic        clear,
  input  logic        reached_in,
  output logic [15:0] bcd_out,
  output logic        overflow,
  output logic        pulse_out
`ifdef SEG_MUX_EN
  ,
  output logic [6:0]  seg,
  output logic [3:0]  an
`endif
);

  generate
    if (SCAN_DIV < 2) begin : g_bad_scan_div
      $error("bcd_event_counter: SCAN_DIV must be at least 2");
    end
  endgenerate

  logic        reached_q, reached_d;
  logic [15:0] count_q, count_d;
  logic        overflow_q, overflow_d;
  logic        pulse_q, pulse_d;
  logic        ev;
  logic [15:0] count_inc;
  logic        count_wrap;

  assign ev = reached_in & ~reached_q;

  // Ripple a decimal carry from units upward; carry out of the top means 9999.
  always_comb begin
    logic       carry;
    logic [3:0] digit;
    carry     = 1'b1;
    count_inc = count_q;
    for (int i = 0; i < 4; i++) begin
      digit = count_q[4*i +: 4];
      if (carry) begin
        if (digit == 4'd9) begin
          count_inc[4*i +: 4] = 4'd0;
        end else begin
          count_inc[4*i +: 4] = digit + 4'd1;
          carry               = 1'b0;
        end
      end
    end
    count_wrap = carry;
  end

  always_comb begin
    reached_d  = reached_in;
    count_d    = count_q;
    overflow_d = overflow_q;
    pulse_d    = 1'b0;
    if (clear) begin
      count_d    = 16'h0000;
      overflow_d = 1'b0;
    end else if (ev && enable) begin
      count_d = count_inc;
      pulse_d = 1'b1;
      if (count_wrap) begin
        overflow_d = 1'b1;
      end
    end
  end

  // reached_q resets high so a level already present at reset release is ignored.
  always_ff @(posedge tick) begin
    if (reset) begin
      reached_q  <= 1'b1;
      count_q    <= 16'h0000;
      overflow_q <= 1'b0;
      pulse_q    <= 1'b0;
    end else begin
      reached_q  <= reached_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      pulse_q    <= pulse_d;
    end
  end

  assign bcd_out   = count_q;
  assign overflow  = overflow_q;
  assign pulse_out = pulse_q;

`ifdef SEG_MUX_EN
  localparam int SCAN_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  logic [SCAN_W-1:0] scan_q, scan_d;
  logic [1:0]        idx_q, idx_d;
  logic [3:0]        an_q, an_d;
  logic [6:0]        seg_q, seg_d;
  logic [3:0]        sel_digit;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'b1000000;
      4'd1:    seg_decode = 7'b1111001;
      4'd2:    seg_decode = 7'b0100100;
      4'd3:    seg_decode = 7'b0110000;
      4'd4:    seg_decode = 7'b0011001;
      4'd5:    seg_decode = 7'b0010010;
      4'd6:    seg_decode = 7'b0000010;
      4'd7:    seg_decode = 7'b1111000;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0010000;
      default: seg_decode = 7'b1111111;
    endcase
  endfunction

  always_comb begin
    scan_d    = scan_q + 1'b1;
    idx_d     = idx_q;
    sel_digit = count_q[{idx_q, 2'b00} +: 4];
    if (scan_q == SCAN_W'(SCAN_DIV - 1)) begin
      scan_d = '0;
      idx_d  = idx_q + 2'd1;
    end
    an_d  = ~(4'b0001 << idx_q);
    seg_d = seg_decode(sel_digit);
  end

  always_ff @(posedge tick) begin
    if (reset) begin
      scan_q <= '0;
      idx_q  <= 2'd0;
      an_q   <= 4'b1110;
      seg_q  <= 7'b1000000;
    end else begin
      scan_q <= scan_d;
      idx_q  <= idx_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bcd_event_counter.sv
// ============================================================================
// Module   : tb_bcd_event_counter
// Brief    : Directed bench for bcd_event_counter with an integer-count model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bcd_event_counter;

  localparam int DIV = 4;

  logic        tick = 1'b0;
  logic        reset, enable, clear, reached_in;
  logic [15:0] bcd_out;
  logic        overflow, pulse_out;
`ifdef SEG_MUX_EN
  logic [6:0]  seg;
  logic [3:0]  an;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int strobes = 0;

  bcd_event_counter #(.SCAN_DIV(DIV)) dut (
    .tick       (tick),
    .reset      (reset),
    .enable     (enable),
    .clear      (clear),
    .reached_in (reached_in),
    .bcd_out    (bcd_out),
    .overflow   (overflow),
    .pulse_out  (pulse_out)
`ifdef SEG_MUX_EN
    ,
    .seg        (seg),
    .an         (an)
`endif
  );

  always #5 tick = ~tick;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    to_bcd = {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Model: the count is a plain integer 0..9999; events are rising edges of reached_in.
  int   m_cnt = 0;
  bit   m_ovf = 0, m_pulse = 0, m_prev = 1, m_valid = 0;
  int   m_k = 0;
  logic [6:0] m_seg;
  logic [3:0] m_an;
  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000};

  always @(posedge tick) begin
    bit ev;
    int slot;
    if (reset) begin
      m_cnt = 0; m_ovf = 0; m_pulse = 0; m_prev = 1; m_valid = 1;
      m_k = 0; m_an = 4'b1110; m_seg = seg_tab[0];
    end else if (m_valid) begin
      slot  = (m_k / DIV) % 4;
      m_an  = ~(4'b0001 << slot);
      case (slot)
        0: m_seg = seg_tab[m_cnt % 10];
        1: m_seg = seg_tab[(m_cnt / 10) % 10];
        2: m_seg = seg_tab[(m_cnt / 100) % 10];
        default: m_seg = seg_tab[(m_cnt / 1000) % 10];
      endcase
      m_k++;
      ev     = reached_in && !m_prev;
      m_prev = reached_in;
      m_pulse = 0;
      if (clear) begin
        m_cnt = 0; m_ovf = 0;
      end else if (ev && enable) begin
        m_pulse = 1;
        if (m_cnt == 9999) begin
          m_cnt = 0; m_ovf = 1;
        end else begin
          m_cnt++;
        end
      end
    end
  end

  always @(posedge tick) begin
    #1;
    if (m_valid) begin
      check("model_bcd", bcd_out, to_bcd(m_cnt));
      check("model_ovf", overflow, m_ovf);
      check("model_pulse", pulse_out, m_pulse);
`ifdef SEG_MUX_EN
      check("model_an", an, m_an);
      check("model_seg", seg, m_seg);
`endif
      if (pulse_out) strobes++;
    end
  end

  task automatic pulse(input int n);
    for (int i = 0; i < n; i++) begin
      reached_in = 1'b1;
      @(negedge tick);
      reached_in = 1'b0;
      @(negedge tick);
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; clear = 1'b0; reached_in = 1'b1;
    repeat (3) @(negedge tick);
    check("rst_bcd", bcd_out, 16'h0000);
    check("rst_ovf", overflow, 1'b0);
    check("rst_pulse", pulse_out, 1'b0);

    // High level at reset release is not an event.
    reset = 1'b0; strobes = 0;
    repeat (5) @(negedge tick);
    check("t1_bcd", bcd_out, 16'h0000);
    check("t1_strobes", strobes, 0);

    enable = 1'b1; reached_in = 1'b0;
    @(negedge tick);
    strobes = 0;
    pulse(12);
    check("t2_bcd", bcd_out, 16'h0012);
    check("t2_strobes", strobes, 12);

    clear = 1'b1; @(negedge tick); clear = 1'b0;
    pulse(9999);
    check("t3_bcd_9999", bcd_out, 16'h9999);
    check("t3_ovf0", overflow, 1'b0);
    strobes = 0;
    pulse(1);
    check("t3_wrap_bcd", bcd_out, 16'h0000);
    check("t3_wrap_ovf", overflow, 1'b1);
    check("t3_wrap_strobes", strobes, 1);
    pulse(1);
    check("t3_after_bcd", bcd_out, 16'h0001);
    check("t3_after_ovf", overflow, 1'b1);

    clear = 1'b1; @(negedge tick); clear = 1'b0;
    pulse(41);
    check("t4_pre_bcd", bcd_out, 16'h0041);
    strobes = 0;
    clear = 1'b1; reached_in = 1'b1;
    @(negedge tick);
    check("t4_clr_bcd", bcd_out, 16'h0000);
    check("t4_clr_ovf", overflow, 1'b0);
    check("t4_clr_pulse", pulse_out, 1'b0);
    clear = 1'b0; reached_in = 1'b0;
    @(negedge tick);
    pulse(1);
    check("t4_next_bcd", bcd_out, 16'h0001);
    check("t4_strobes", strobes, 1);

    enable = 1'b0;
    pulse(3);
    check("t5_hold_bcd", bcd_out, 16'h0001);
    reached_in = 1'b1;
    @(negedge tick);
    enable = 1'b1;
    repeat (2) @(negedge tick);
    check("t5_late_enable", bcd_out, 16'h0001);
    reached_in = 1'b0;
    @(negedge tick);
    pulse(1);
    check("t5_next_bcd", bcd_out, 16'h0002);

    pulse(5);
    check("rst_mid_pre", bcd_out, 16'h0007);
    reset = 1'b1;
    @(negedge tick);
    check("rst_mid_bcd", bcd_out, 16'h0000);
    reset = 1'b0;
    @(negedge tick);
    pulse(1);
    check("rst_mid_next", bcd_out, 16'h0001);

`ifdef SEG_MUX_EN
    clear = 1'b1; @(negedge tick); clear = 1'b0;
    pulse(1234);
    check("t6_bcd", bcd_out, 16'h1234);
    repeat (DIV * 8) @(negedge tick);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
